ir_key_ctrl: RTL and testbench

//   Key-event controller between the NEC IR receiver and the application/display logic.
//   - Validates each 32-bit frame (address and command complements), latches the key and

---
 rtl/ir_key_ctrl.sv | 149 ++++++++++++++
 tb/tb_ir_key_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_key_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ir_key_ctrl : NEC frame check, key strobes, auto-repeat and release timing
// Rev 1.0     : optional IR_ADDR_FILTER_EN restricts accepted frames to ADDR_MATCH
// ----------------------------------------------------------------------------
module ir_key_ctrl #(
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned REPEAT_DLY_MS  = 500,
  parameter int unsigned REPEAT_RATE_MS = 110,
  parameter int unsigned RELEASE_MS     = 120,
  parameter logic [7:0]  ADDR_MATCH     = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_frame,
  input  logic        i_frame_vld,
  input  logic        i_repeat,
  output logic [7:0]  o_key,
  output logic [7:0]  o_addr,
  output logic        o_key_vld,
  output logic        o_key_held,
  output logic [7:0]  o_err_cnt
);

  localparam int unsigned c_PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned c_TMAX = (REPEAT_DLY_MS > REPEAT_RATE_MS) ?
                                   ((REPEAT_DLY_MS > RELEASE_MS) ? REPEAT_DLY_MS : RELEASE_MS) :
                                   ((REPEAT_RATE_MS > RELEASE_MS) ? REPEAT_RATE_MS : RELEASE_MS);
  localparam int unsigned c_TW   = $clog2(c_TMAX + 1);

  localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(TICK_DIV - 1);
  localparam logic [c_TW-1:0] c_DLY_LAST   = c_TW'(REPEAT_DLY_MS - 1);
  localparam logic [c_TW-1:0] c_RATE_LAST  = c_TW'(REPEAT_RATE_MS - 1);
  localparam logic [c_TW-1:0] c_REL_LAST   = c_TW'(RELEASE_MS - 1);

`ifdef IR_ADDR_FILTER_EN
  localparam logic c_FILTER = 1'b1;
`else
  localparam logic c_FILTER = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [c_PW-1:0] presc_q, presc_d;
  logic [c_TW-1:0] hold_q, hold_d;
  logic [c_TW-1:0] rel_q, rel_d;
  logic [7:0]      key_q, key_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      err_q, err_d;
  logic            vld_q, vld_d;
  logic            pend_q, pend_d;

  logic w_tick, w_valid, w_accept, w_bad, w_rep, w_evt, w_fire;

  assign w_tick   = (presc_q == c_PRESC_LAST);
  assign w_valid  = (i_frame[31:24] == ~i_frame[23:16]) && (i_frame[15:8] == ~i_frame[7:0]);
  assign w_accept = i_frame_vld & w_valid & (~c_FILTER | (i_frame[31:24] == ADDR_MATCH));
  assign w_bad    = i_frame_vld & ~w_valid;
  // Any frame strobe, even a dropped one, swallows a coincident repeat code.
  assign w_rep    = i_repeat & ~i_frame_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      hold_q  <= '0;
      rel_q   <= '0;
      key_q   <= '0;
      addr_q  <= '0;
      err_q   <= '0;
      vld_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      rel_q   <= rel_d;
      key_q   <= key_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    presc_d = w_tick ? '0 : presc_q + c_PW'(1);
    state_d = state_q;
    hold_d  = hold_q;
    rel_d   = rel_q;
    key_d   = key_q;
    addr_d  = addr_q;
    err_d   = err_q;
    w_evt   = 1'b0;

    if (w_bad && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end

    if (w_accept) begin
      key_d   = i_frame[15:8];
      addr_d  = i_frame[31:24];
      state_d = S_PRESS;
      hold_d  = '0;
      rel_d   = '0;
      w_evt   = 1'b1;
    end else if (state_q != S_IDLE) begin
      if (w_rep) begin
        rel_d = '0;
      end else if (w_tick) begin
        if (rel_q == c_REL_LAST) begin
          state_d = S_IDLE;
          hold_d  = '0;
          rel_d   = '0;
        end else begin
          rel_d = rel_q + c_TW'(1);
        end
      end
      // A release on this tick takes precedence over a due auto-repeat.
      if (w_tick && (state_d != S_IDLE)) begin
        if (hold_q == ((state_q == S_PRESS) ? c_DLY_LAST : c_RATE_LAST)) begin
          w_evt   = 1'b1;
          hold_d  = '0;
          state_d = S_HOLD;
        end else begin
          hold_d = hold_q + c_TW'(1);
        end
      end
    end

    // An auto strobe followed immediately by a new press defers the press strobe one cycle.
    w_fire = w_evt | pend_q;
    vld_d  = w_fire & ~vld_q;
    pend_d = w_fire & vld_q;
  end

  assign o_key      = key_q;
  assign o_addr     = addr_q;
  assign o_key_vld  = vld_q;
  assign o_key_held = (state_q != S_IDLE);
  assign o_err_cnt  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_key_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ir_key_ctrl : directed + random stimulus, ms-scheduled model, strobe scoreboard
// ----------------------------------------------------------------------------
module tb_ir_key_ctrl;

  localparam int TD = 10, DLY = 5, RATE = 3, REL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] frame = '0;
  logic        fvld = 1'b0;
  logic        rep = 1'b0;
  logic [7:0]  key, addr, err_cnt;
  logic        kvld, held;

  ir_key_ctrl #(
    .TICK_DIV(TD), .REPEAT_DLY_MS(DLY), .REPEAT_RATE_MS(RATE),
    .RELEASE_MS(REL), .ADDR_MATCH(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_frame(frame), .i_frame_vld(fvld), .i_repeat(rep),
    .o_key(key), .o_addr(addr), .o_key_vld(kvld), .o_key_held(held), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  typedef struct { logic [7:0] k; logic [7:0] a; int en; } exp_t;
  exp_t exp_q[$];
  int   st_q[$];
  int   scnt = 0;

  // Reference model: events scheduled on absolute millisecond indices.
  int         n = 0, ms = 0, next_ms = 0, rel_ms = 0, last_e = -10;
  bit         m_held = 1'b0;
  logic [7:0] m_key = '0, m_addr = '0, m_err = '0;
  bit         prev_kvld = 1'b0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, n);
    end
  endtask

  task automatic chk_rng(input string name, input longint v, input longint lo, input longint hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s: got %0d required %0d..%0d", name, v, lo, hi);
    end
  endtask

  function automatic bit frame_ok(input logic [31:0] f);
    return ((f[31:24] ^ f[23:16]) == 8'hFF) && ((f[15:8] ^ f[7:0]) == 8'hFF);
  endfunction

  function automatic void push_exp();
    int e;
    e = (last_e == n - 1) ? n + 1 : n;
    exp_q.push_back('{k: m_key, a: m_addr, en: e});
    last_e = e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; ms = 0; m_held = 1'b0; m_key = '0; m_addr = '0; m_err = '0; last_e = -10;
      exp_q.delete();
    end else begin
      bit tick, acc;
      n++;
      tick = ((n % TD) == 0);
      if (tick) ms++;
      acc = fvld && frame_ok(frame);
`ifdef IR_ADDR_FILTER_EN
      if (frame[31:24] != 8'h00) acc = 1'b0;
`endif
      if (fvld && !frame_ok(frame) && m_err != 8'hFF) m_err++;
      if (acc) begin
        m_key = frame[15:8]; m_addr = frame[31:24]; m_held = 1'b1;
        next_ms = ms + DLY; rel_ms = ms + REL;
        push_exp();
      end else if (m_held) begin
        if (rep && !fvld) rel_ms = ms + REL;
        if (tick && ms == rel_ms) m_held = 1'b0;
        else if (tick && ms == next_ms) begin
          push_exp();
          next_ms = ms + RATE;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t x;
      chk("state", {key, addr, 7'd0, held, err_cnt}, {m_key, m_addr, 7'd0, m_held, m_err});
      if (kvld) begin
        scnt++;
        st_q.push_back(n);
        chk("vld_gap", prev_kvld, 0);
        if (exp_q.size() == 0) begin
          chk("strobe_expected", exp_q.size(), 1);
        end else begin
          x = exp_q.pop_front();
          chk("strobe_key", key, x.k);
          chk("strobe_addr", addr, x.a);
          chk("strobe_cycle", n, x.en);
        end
      end else if (exp_q.size() > 0 && exp_q[0].en <= n) begin
        chk("strobe_missing", kvld, 1);
        x = exp_q.pop_front();
      end
      prev_kvld = kvld;
    end else begin
      prev_kvld = 1'b0;
    end
  end

  task automatic cyc(input int k);
    repeat (k) begin @(negedge clk); #1; end
  endtask

  task automatic send_frame(input logic [31:0] f);
    frame = f; fvld = 1'b1; cyc(1); fvld = 1'b0;
  endtask

  task automatic send_rep();
    rep = 1'b1; cyc(1); rep = 1'b0;
  endtask

  task automatic wait_release(output int c);
    c = 0;
    while (held && c < 200) begin cyc(1); c++; end
    if (held) chk("release_timeout", held, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int c, s0, gap, r;
    logic [7:0] ra, rc;
    cyc(3);
    chk("reset_outputs", {key, addr, kvld, held, err_cnt}, 0);
    rst_n = 1'b1;

    s0 = scnt; cyc(1000);
    chk("idle_no_strobe", scnt - s0, 0);

    st_q.delete();
    send_frame(32'h00FF_45BA);
    chk("press_key", key, 8'h45);
    chk("press_addr", addr, 8'h00);
    chk("press_vld", kvld, 1);
    chk("press_held", held, 1);
    cyc(1);
    chk("press_vld_width", kvld, 0);
    wait_release(c);
    chk_rng("release_no_repeat", c + 1, 30, 40);
    cyc(60);
    chk("press_only_strobe", st_q.size(), 1);

    st_q.delete();
    send_frame(32'h00FF_45BA);
    repeat (10) begin cyc(29); send_rep(); end
    wait_release(c);
    chk_rng("release_after_repeat", c, 30, 40);
    chk("auto_strobes_seen", st_q.size() >= 3, 1);
    if (st_q.size() >= 2) chk_rng("first_auto", st_q[1] - st_q[0], 40, 50);
    for (int i = 2; i < st_q.size(); i++) chk_rng("auto_gap", st_q[i] - st_q[i-1], 20, 30);

    s0 = scnt;
    send_frame(32'h00FF_4545); cyc(2);
    chk("bad_err_cnt", err_cnt, 1);
    chk("bad_no_strobe", scnt - s0, 0);
    chk("bad_key_kept", key, 8'h45);
    repeat (300) send_frame(32'h00FF_4545);
    cyc(1);
    chk("err_saturate", err_cnt, 255);

    send_frame(32'h00FF_45BA); cyc(19); send_rep(); cyc(19); send_rep();
    s0 = scnt; c = 0;
    while (scnt == s0 && c < 30) begin cyc(1); c++; end
    chk("hold_reached", scnt - s0, 1);
    cyc(3); st_q.delete(); s0 = scnt;
    frame = 32'h00FF_3AC5; fvld = 1'b1; rep = 1'b1; cyc(1); fvld = 1'b0; rep = 1'b0;
    cyc(2);
    chk("simul_one_strobe", scnt - s0, 1);
    chk("simul_key", key, 8'h3A);
    repeat (4) begin cyc(17); send_rep(); end
    chk("simul_restart_seen", st_q.size() >= 2, 1);
    if (st_q.size() >= 2) chk_rng("simul_first_auto", st_q[1] - st_q[0], 40, 50);
    wait_release(c);

    s0 = scnt; send_rep(); cyc(20);
    chk("idle_repeat_no_strobe", scnt - s0, 0);
    chk("idle_repeat_held", held, 0);

    s0 = scnt; send_frame(32'h01FE_45BA); cyc(1);
`ifdef IR_ADDR_FILTER_EN
    chk("filter_drop", scnt - s0, 0);
    chk("filter_err_kept", err_cnt, 255);
`else
    chk("any_addr_strobe", scnt - s0, 1);
    chk("any_addr_value", addr, 8'h01);
`endif
    wait_release(c);
    send_frame(32'h00FF_45BA);
    chk("addr0_accept", kvld, 1);

    cyc(10);
    rst_n = 1'b0; #1;
    chk("mid_reset_outputs", {key, addr, kvld, held, err_cnt}, 0);
    cyc(3); rst_n = 1'b1;
    s0 = scnt; cyc(50);
    chk("post_reset_no_strobe", scnt - s0, 0);
    chk("post_reset_held", held, 0);

    gap = 5;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 4 && gap >= 1) begin
        ra = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        rc = 8'($urandom_range(0, 255));
        frame = {ra, ~ra, rc, ~rc};
        fvld = 1'b1;
        rep = ($urandom_range(0, 3) == 0);
        gap = 0;
      end else if (r < 6 && gap >= 1) begin
        frame = $urandom;
        fvld = 1'b1;
        gap = 0;
      end else begin
        if (r < 16) rep = 1'b1;
        gap++;
      end
      cyc(1);
      fvld = 1'b0; rep = 1'b0;
    end
    cyc(100);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
